// File: rtl/bellek_hakem_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
// Holds the word width, default RAM depth, error codes and the address legality check.
package bellek_hakem_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned DEPTH_DEF = 512;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_ALIGN = 2'd1,
    ERR_RANGE = 2'd2
  } err_code_e;

  // Round-robin pointer: which requester received the most recent grant
  typedef enum logic {
    LAST_M0 = 1'b0,
    LAST_M1 = 1'b1
  } rr_last_e;

  typedef struct packed {
    logic              wen;
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
  } acc_t;

  // An access is legal only if it is word aligned and its word index is inside the RAM
  function automatic err_code_e acc_check(input logic [ADDR_W-1:0] addr,
                                          input int unsigned depth);
    if (addr[1:0] != 2'b00) return ERR_ALIGN;
    if (ADDR_W'(addr[ADDR_W-1:2]) >= ADDR_W'(depth)) return ERR_RANGE;
    return ERR_NONE;
  endfunction

endpackage

// File: rtl/bellek_hakem_if.sv
// Bus bundle between the two requesters, the arbiter and the attached RAM.
// The slave modport is the arbiter's view; the master modport is the system's view.
interface bellek_hakem_if;
  import bellek_hakem_pkg::*;

  logic              m0_req_i;
  logic [ADDR_W-1:0] m0_addr_i;
  logic              m0_gnt_o;
  logic              m0_rvalid_o;
  logic [WORD_W-1:0] m0_rdata_o;
  logic              m0_err_o;

  logic              m1_req_i;
  logic              m1_wen_i;
  logic [ADDR_W-1:0] m1_addr_i;
  logic [WORD_W-1:0] m1_wdata_i;
  logic              m1_gnt_o;
  logic              m1_rvalid_o;
  logic [WORD_W-1:0] m1_rdata_o;
  logic              m1_err_o;

  logic              mem_wen_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [WORD_W-1:0] mem_data_o;
  logic [WORD_W-1:0] mem_data_i;

  modport slave (
    input  m0_req_i, m0_addr_i,
    output m0_gnt_o, m0_rvalid_o, m0_rdata_o, m0_err_o,
    input  m1_req_i, m1_wen_i, m1_addr_i, m1_wdata_i,
    output m1_gnt_o, m1_rvalid_o, m1_rdata_o, m1_err_o,
    output mem_wen_o, mem_addr_o, mem_data_o,
    input  mem_data_i
  );

  modport master (
    output m0_req_i, m0_addr_i,
    input  m0_gnt_o, m0_rvalid_o, m0_rdata_o, m0_err_o,
    output m1_req_i, m1_wen_i, m1_addr_i, m1_wdata_i,
    input  m1_gnt_o, m1_rvalid_o, m1_rdata_o, m1_err_o,
    input  mem_wen_o, mem_addr_o, mem_data_o,
    output mem_data_i
  );

endinterface

// File: rtl/bellek_hakem_rr2.sv
// Two-way round-robin grant logic; grant is combinational, the pointer is the only state.
// On a tie the requester that was not granted most recently wins.
module hakem_rr2
  import bellek_hakem_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req,
  output logic [1:0] gnt_c
);

  rr_last_e last_q, last_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) last_q <= LAST_M1;
    else         last_q <= last_d;
  end

  // Grant selection and pointer update
  always_comb begin
    gnt_c  = 2'b00;
    last_d = last_q;
    if (req == 2'b11) gnt_c = (last_q == LAST_M1) ? 2'b01 : 2'b10;
    else              gnt_c = req;
    if (gnt_c[1])      last_d = LAST_M1;
    else if (gnt_c[0]) last_d = LAST_M0;
  end

endmodule

// File: rtl/bellek_hakem.sv
// Arbiter between a read-only fetch port (m0) and a load/store port (m1) sharing one RAM.
// Grants are combinational; each grant yields a one-cycle response on the grantee's port.
module bellek_hakem
  import bellek_hakem_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF
)(
  input  logic          clk_i,
  input  logic          rst_ni,
  bellek_hakem_if.slave bus
);

  logic [1:0]        req_c;
  logic [1:0]        gnt_c;
  logic              any_c;
  logic              legal_c;
  err_code_e         chk_c;
  acc_t              acc_c;
  logic [ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0] data_q;
  logic [1:0]        rvalid_q;
  logic [1:0]        err_q;
  logic [WORD_W-1:0] rdata_q [2];

  // Requests are ignored while reset is held so nothing is granted into a reset
  assign req_c = {bus.m1_req_i, bus.m0_req_i} & {2{rst_ni}};

  hakem_rr2 u_rr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .req    (req_c),
    .gnt_c  (gnt_c)
  );

  // Payload of the granted requester; m0 never writes
  always_comb begin
    acc_c.wen   = 1'b0;
    acc_c.addr  = bus.m0_addr_i;
    acc_c.wdata = '0;
    if (gnt_c[1]) begin
      acc_c.wen   = bus.m1_wen_i;
      acc_c.addr  = bus.m1_addr_i;
      acc_c.wdata = bus.m1_wdata_i;
    end
  end

  assign any_c   = |gnt_c;
  assign chk_c   = acc_check(acc_c.addr, DEPTH);
  assign legal_c = (chk_c == ERR_NONE);

  assign bus.m0_gnt_o   = gnt_c[0];
  assign bus.m1_gnt_o   = gnt_c[1];
  assign bus.mem_wen_o  = any_c & acc_c.wen & legal_c;
  assign bus.mem_addr_o = any_c ? acc_c.addr : addr_q;
  assign bus.mem_data_o = (any_c && acc_c.wen) ? acc_c.wdata : data_q;

  // Last driven RAM address/data, held while no access is granted
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q <= '0;
      data_q <= '0;
    end else begin
      if (any_c)             addr_q <= acc_c.addr;
      if (any_c & acc_c.wen) data_q <= acc_c.wdata;
    end
  end

  // Per-port response registers; writes leave rdata untouched, errors zero it
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 2'b00;
      err_q    <= 2'b00;
      for (int p = 0; p < 2; p++) rdata_q[p] <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        rvalid_q[p] <= gnt_c[p];
        err_q[p]    <= gnt_c[p] & ~legal_c;
        if (gnt_c[p]) begin
          if (!legal_c)       rdata_q[p] <= '0;
          else if (!acc_c.wen) rdata_q[p] <= bus.mem_data_i;
        end
      end
    end
  end

  assign bus.m0_rvalid_o = rvalid_q[0];
  assign bus.m0_err_o    = err_q[0];
  assign bus.m0_rdata_o  = rdata_q[0];
  assign bus.m1_rvalid_o = rvalid_q[1];
  assign bus.m1_err_o    = err_q[1];
  assign bus.m1_rdata_o  = rdata_q[1];

endmodule

// File: tb/tb_bellek_hakem.sv
// Directed bench for bellek_hakem with a behavioural RAM (sync write, async read).
// RAM word i holds 0xA000_0000 + i out of reset.
module tb_bellek_hakem;
  import bellek_hakem_pkg::*;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  int   errors = 0;
  int   checks = 0;
  logic [5:0]  exp_m0 = 6'b010101;
  logic [31:0] ram [512];

  bellek_hakem_if bus ();

  bellek_hakem #(.DEPTH(512)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  assign bus.mem_data_i = ram[bus.mem_addr_o[10:2]];

  always @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < 512; i++) ram[i] <= 32'hA000_0000 + 32'(i);
    end else if (bus.mem_wen_o) begin
      ram[bus.mem_addr_o[10:2]] <= bus.mem_data_o;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    bus.m0_req_i   = 1'b0;
    bus.m0_addr_i  = '0;
    bus.m1_req_i   = 1'b0;
    bus.m1_wen_i   = 1'b0;
    bus.m1_addr_i  = '0;
    bus.m1_wdata_i = '0;
  endtask

  initial begin
    idle();
    // Reset state
    #12;
    chk("rst_m0_rvalid", 32'(bus.m0_rvalid_o), 32'd0);
    chk("rst_m1_rvalid", 32'(bus.m1_rvalid_o), 32'd0);
    chk("rst_m0_err",    32'(bus.m0_err_o),    32'd0);
    chk("rst_m1_err",    32'(bus.m1_err_o),    32'd0);
    chk("rst_m0_rdata",  bus.m0_rdata_o,       32'd0);
    chk("rst_m1_rdata",  bus.m1_rdata_o,       32'd0);
    chk("rst_mem_wen",   32'(bus.mem_wen_o),   32'd0);
    #11 rst_ni = 1'b1;
    tick();

    // m0 reads 0x10 alone
    bus.m0_req_i = 1'b1; bus.m0_addr_i = 32'h10;
    #1;
    chk("rd10_m0_gnt",   32'(bus.m0_gnt_o),  32'd1);
    chk("rd10_m1_gnt",   32'(bus.m1_gnt_o),  32'd0);
    chk("rd10_mem_addr", bus.mem_addr_o,     32'h10);
    chk("rd10_mem_wen",  32'(bus.mem_wen_o), 32'd0);
    tick();
    bus.m0_req_i = 1'b0;
    chk("rd10_m0_rvalid", 32'(bus.m0_rvalid_o), 32'd1);
    chk("rd10_m0_rdata",  bus.m0_rdata_o,       32'hA000_0004);
    chk("rd10_m0_err",    32'(bus.m0_err_o),    32'd0);
    chk("rd10_m1_rvalid", 32'(bus.m1_rvalid_o), 32'd0);

    // m1 writes 0xDEADBEEF to 0x20, then m0 reads it back
    bus.m1_req_i = 1'b1; bus.m1_wen_i = 1'b1;
    bus.m1_addr_i = 32'h20; bus.m1_wdata_i = 32'hDEAD_BEEF;
    #1;
    chk("wr20_m1_gnt",   32'(bus.m1_gnt_o),  32'd1);
    chk("wr20_mem_wen",  32'(bus.mem_wen_o), 32'd1);
    chk("wr20_mem_addr", bus.mem_addr_o,     32'h20);
    chk("wr20_mem_data", bus.mem_data_o,     32'hDEAD_BEEF);
    tick();
    idle();
    chk("wr20_m1_rvalid", 32'(bus.m1_rvalid_o), 32'd1);
    chk("wr20_m1_err",    32'(bus.m1_err_o),    32'd0);
    chk("wr20_m1_rdata",  bus.m1_rdata_o,       32'd0);
    chk("wr20_m0_rvalid", 32'(bus.m0_rvalid_o), 32'd0);
    bus.m0_req_i = 1'b1; bus.m0_addr_i = 32'h20;
    #1;
    chk("rd20_m0_gnt", 32'(bus.m0_gnt_o), 32'd1);
    tick();
    idle();
    chk("rd20_m0_rvalid", 32'(bus.m0_rvalid_o), 32'd1);
    chk("rd20_m0_rdata",  bus.m0_rdata_o,       32'hDEAD_BEEF);

    // No grant: RAM side holds last driven values
    #1;
    chk("idle_mem_wen",  32'(bus.mem_wen_o), 32'd0);
    chk("idle_mem_addr", bus.mem_addr_o,     32'h20);
    chk("idle_mem_data", bus.mem_data_o,     32'hDEAD_BEEF);
    tick();
    chk("idle_m0_rvalid", 32'(bus.m0_rvalid_o), 32'd0);

    // m1 legal read of 0x8 loads a non-zero rdata
    bus.m1_req_i = 1'b1; bus.m1_wen_i = 1'b0; bus.m1_addr_i = 32'h8;
    #1;
    tick();
    chk("rd08_m1_rdata", bus.m1_rdata_o, 32'hA000_0002);

    // Misaligned write
    bus.m1_wen_i = 1'b1; bus.m1_addr_i = 32'h802; bus.m1_wdata_i = 32'h1234_5678;
    #1;
    chk("wr802_m1_gnt",  32'(bus.m1_gnt_o),  32'd1);
    chk("wr802_mem_wen", 32'(bus.mem_wen_o), 32'd0);
    tick();
    chk("wr802_m1_rvalid", 32'(bus.m1_rvalid_o), 32'd1);
    chk("wr802_m1_err",    32'(bus.m1_err_o),    32'd1);
    chk("wr802_m1_rdata",  bus.m1_rdata_o,       32'd0);

    // Out-of-range write (word 512)
    bus.m1_addr_i = 32'h800;
    #1;
    chk("wr800_mem_wen", 32'(bus.mem_wen_o), 32'd0);
    tick();
    idle();
    chk("wr800_m1_rvalid", 32'(bus.m1_rvalid_o), 32'd1);
    chk("wr800_m1_err",    32'(bus.m1_err_o),    32'd1);

    // Both illegal addresses alias word 0 in the RAM model: it must be intact
    bus.m0_req_i = 1'b1; bus.m0_addr_i = 32'h0;
    #1;
    tick();
    idle();
    chk("rd00_m0_rdata", bus.m0_rdata_o,    32'hA000_0000);
    chk("rd00_m0_err",   32'(bus.m0_err_o), 32'd0);

    // m0 granted last, then reset asserted between clock edges
    bus.m0_req_i = 1'b1; bus.m0_addr_i = 32'hC;
    #1;
    tick();
    idle();
    chk("rd0c_m0_rdata", bus.m0_rdata_o, 32'hA000_0003);
    #3 rst_ni = 1'b0;
    #1;
    chk("arst_m0_rvalid", 32'(bus.m0_rvalid_o), 32'd0);
    chk("arst_m0_rdata",  bus.m0_rdata_o,       32'd0);
    chk("arst_m0_err",    32'(bus.m0_err_o),    32'd0);
    chk("arst_m1_rdata",  bus.m1_rdata_o,       32'd0);
    chk("arst_m1_err",    32'(bus.m1_err_o),    32'd0);
    chk("arst_mem_wen",   32'(bus.mem_wen_o),   32'd0);
    #10 rst_ni = 1'b1;
    tick();

    // Both requesting continuously: alternate starting with m0
    bus.m0_req_i = 1'b1; bus.m0_addr_i = 32'h40;
    bus.m1_req_i = 1'b1; bus.m1_wen_i = 1'b0; bus.m1_addr_i = 32'h44;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("rr%0d_m0_gnt", i), 32'(bus.m0_gnt_o), 32'(exp_m0[i]));
      chk($sformatf("rr%0d_m1_gnt", i), 32'(bus.m1_gnt_o), 32'(!exp_m0[i]));
      tick();
      chk($sformatf("rr%0d_m0_rvalid", i), 32'(bus.m0_rvalid_o), 32'(exp_m0[i]));
      chk($sformatf("rr%0d_m1_rvalid", i), 32'(bus.m1_rvalid_o), 32'(!exp_m0[i]));
      if (exp_m0[i]) chk($sformatf("rr%0d_m0_rdata", i), bus.m0_rdata_o, 32'hA000_0010);
      else           chk($sformatf("rr%0d_m1_rdata", i), bus.m1_rdata_o, 32'hA000_0011);
    end
    idle();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
